// File: rtl/rf_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int RF_NREQ = 3;
    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;

    typedef enum logic [1:0] {
        REQ_ALU = 2'd0,
        REQ_LSU = 2'd1,
        REQ_DBG = 2'd2
    } req_id_e;

    // Round-robin successor of a requester index.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr wins.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int PW   = ptr_w(RF_NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [PW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   idx_o
);

    int            w_cand;
    logic [PW-1:0] w_cand_idx;
    logic          w_found;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        grant_o    = '0;
        idx_o      = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = int'(ptr_i) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            w_cand_idx = PW'(w_cand);
            if (en_i && !w_found && valid_i[w_cand_idx]) begin
                w_found             = 1'b1;
                grant_o[w_cand_idx] = 1'b1;
                idx_o               = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port; one-entry output stage,
// freeze stalls acceptance and writes, writes to x0 are absorbed and counted.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze_i,
    input  logic [NREQ-1:0]  req_valid_i,
    output logic [NREQ-1:0]  req_ready_o,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic             rf_we_o,
    output logic [AW-1:0]    rf_wa_o,
    output logic [DW-1:0]    rf_wd_o,
    output logic [NREQ-1:0]  grant_o,
    output logic [15:0]      wr_cnt_o,
    output logic [7:0]       x0_cnt_o
);

    localparam int PW = ptr_w(NREQ);

    logic [PW-1:0]   r_ptr;
    logic            r_pend;
    logic [AW-1:0]   r_wa;
    logic [DW-1:0]   r_wd;
    logic [NREQ-1:0] r_grant;
    logic [15:0]     r_wr_cnt;
    logic [7:0]      r_x0_cnt;

    logic            w_en;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    assign w_en = !freeze_i && !rst;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (r_ptr),
        .en_i    (w_en),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    assign req_ready_o = w_grant;
    assign w_xfer      = |w_grant;
    assign w_sel_addr  = req_addr_i[int'(w_idx)*AW +: AW];
    assign w_sel_data  = req_data_i[int'(w_idx)*DW +: DW];

    // A pending write caught by reset is dropped, so reset also masks the enable.
    assign rf_we_o  = r_pend && !freeze_i && !rst;
    assign rf_wa_o  = r_wa;
    assign rf_wd_o  = r_wd;
    assign grant_o  = r_grant;
    assign wr_cnt_o = r_wr_cnt;
    assign x0_cnt_o = r_x0_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= PW'(REQ_ALU);
            r_pend   <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_grant  <= '0;
            r_wr_cnt <= '0;
            r_x0_cnt <= '0;
        end else begin
            if (rf_we_o) begin
                r_pend   <= 1'b0;
                r_grant  <= '0;
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
            if (w_xfer) begin
                r_ptr <= PW'(rr_next(int'(w_idx), NREQ));
                if (w_sel_addr != '0) begin
                    r_pend  <= 1'b1;
                    r_wa    <= w_sel_addr;
                    r_wd    <= w_sel_data;
                    r_grant <= w_grant;
                end else if (r_x0_cnt != 8'hFF) begin
                    r_x0_cnt <= r_x0_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter: directed scenarios plus randomized traffic
// against a queue-based model of accepted-but-uncommitted writes.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        freeze_i;
    logic [2:0]  req_valid_i;
    logic [2:0]  req_ready_o;
    logic [14:0] req_addr_i;
    logic [95:0] req_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_wa_o;
    logic [31:0] rf_wd_o;
    logic [2:0]  grant_o;
    logic [15:0] wr_cnt_o;
    logic [7:0]  x0_cnt_o;

    rf_wr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .freeze_i    (freeze_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .rf_we_o     (rf_we_o),
        .rf_wa_o     (rf_wa_o),
        .rf_wd_o     (rf_wd_o),
        .grant_o     (grant_o),
        .wr_cnt_o    (wr_cnt_o),
        .x0_cnt_o    (x0_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  g;
    } wr_t;

    int          n_cmp;
    int          n_bad;
    logic [4:0]  a [3];
    logic [31:0] d [3];

    // Reference model: writes accepted but not yet committed, pointer, counters.
    wr_t         q [$];
    int          m_ptr;
    int          m_wr;
    int          m_x0;

    logic [4:0]  commit_log [$];
    logic [2:0]  rdy_log [$];
    logic        we_log [$];

    function automatic int pick(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic clear_logs();
        commit_log.delete();
        rdy_log.delete();
        we_log.delete();
    endtask

    // One clock cycle: drive at the falling edge, compare outputs, advance the model.
    task automatic run_cycle(input logic [2:0] v, input logic frz, input logic r);
        int         w;
        logic [2:0] exp_rdy;
        logic       exp_we;
        logic [2:0] exp_g;
        @(negedge clk);
        rst         = r;
        freeze_i    = frz;
        req_valid_i = v;
        for (int i = 0; i < 3; i++) begin
            req_addr_i[i*5 +: 5]   = a[i];
            req_data_i[i*32 +: 32] = d[i];
        end
        #1;
        w       = (r || frz) ? -1 : pick(v, m_ptr);
        exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
        exp_we  = !r && !frz && (q.size() != 0);
        exp_g   = (q.size() != 0) ? q[0].g : 3'b000;

        n_cmp++;
        if (req_ready_o !== exp_rdy) begin
            n_bad++;
            $display("FAIL ready: got %b want %b at %0t", req_ready_o, exp_rdy, $time);
        end
        n_cmp++;
        if (rf_we_o !== exp_we) begin
            n_bad++;
            $display("FAIL rf_we: got %b want %b at %0t", rf_we_o, exp_we, $time);
        end
        n_cmp++;
        if (grant_o !== exp_g) begin
            n_bad++;
            $display("FAIL grant: got %b want %b at %0t", grant_o, exp_g, $time);
        end
        if (q.size() != 0) begin
            n_cmp++;
            if (rf_wa_o !== q[0].wa || rf_wd_o !== q[0].wd) begin
                n_bad++;
                $display("FAIL wa/wd: got %0d/%h want %0d/%h at %0t",
                         rf_wa_o, rf_wd_o, q[0].wa, q[0].wd, $time);
            end
        end
        n_cmp++;
        if (wr_cnt_o !== 16'(m_wr) || x0_cnt_o !== 8'(m_x0)) begin
            n_bad++;
            $display("FAIL counters: got wr=%0d x0=%0d want wr=%0d x0=%0d at %0t",
                     wr_cnt_o, x0_cnt_o, m_wr, m_x0, $time);
        end

        rdy_log.push_back(req_ready_o);
        we_log.push_back(rf_we_o);
        if (rf_we_o === 1'b1) commit_log.push_back(rf_wa_o);

        if (r) begin
            q.delete();
            m_ptr = 0;
            m_wr  = 0;
            m_x0  = 0;
        end else begin
            if (exp_we) begin
                void'(q.pop_front());
                m_wr = (m_wr + 1) % 65536;
            end
            if (w >= 0) begin
                m_ptr = (w + 1) % 3;
                if (a[w] != 5'd0) q.push_back('{a[w], d[w], 3'(1 << w)});
                else if (m_x0 < 255) m_x0++;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        run_cycle(3'b000, 1'b0, 1'b1);
        run_cycle(3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (rf_we_o !== 1'b0 || rf_wa_o !== 5'd0 || rf_wd_o !== 32'd0 || grant_o !== 3'b000 ||
            req_ready_o !== 3'b000 || wr_cnt_o !== 16'd0 || x0_cnt_o !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_values: we=%b wa=%0d wd=%h g=%b rdy=%b wr=%0d x0=%0d want all zero",
                     rf_we_o, rf_wa_o, rf_wd_o, grant_o, req_ready_o, wr_cnt_o, x0_cnt_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        clear_logs();
        a[0] = 5'd5;
        d[0] = 32'h1234;
        run_cycle(3'b001, 1'b0, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (rdy_log[0] !== 3'b001 || we_log[1] !== 1'b1 || commit_log.size() != 1) begin
            n_bad++;
            $display("FAIL single: rdy0=%b we1=%b commits=%0d want 001/1/1",
                     rdy_log[0], we_log[1], commit_log.size());
        end
        n_cmp++;
        if (wr_cnt_o !== 16'd1) begin
            n_bad++;
            $display("FAIL single_wr_cnt: got %0d want 1", wr_cnt_o);
        end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_rdy [6];
        logic [4:0] exp_commit [6];
        exp_rdy    = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_commit = '{5'd10, 5'd11, 5'd12, 5'd10, 5'd11, 5'd12};
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            a[i] = 5'(10 + i);
            d[i] = 32'hA000 + 32'(i);
        end
        for (int c = 0; c < 6; c++) run_cycle(3'b111, 1'b0, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if (rdy_log[c] !== exp_rdy[c] || we_log[c+1] !== 1'b1) begin
                n_bad++;
                $display("FAIL fairness[%0d]: rdy=%b we_next=%b want %b/1",
                         c, rdy_log[c], we_log[c+1], exp_rdy[c]);
            end
        end
        n_cmp++;
        if (commit_log.size() != 6 || we_log[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL fairness_commits: got %0d commits we0=%b want 6/0",
                     commit_log.size(), we_log[0]);
        end else begin
            for (int c = 0; c < 6; c++) begin
                n_cmp++;
                if (commit_log[c] !== exp_commit[c]) begin
                    n_bad++;
                    $display("FAIL fairness_order[%0d]: got %0d want %0d",
                             c, commit_log[c], exp_commit[c]);
                end
            end
        end
    endtask

    task automatic test_x0();
        do_reset();
        clear_logs();
        a[1] = 5'd0;
        d[1] = 32'hFFFF;
        run_cycle(3'b010, 1'b0, 1'b0);
        a[0] = 5'd1;
        a[1] = 5'd2;
        a[2] = 5'd3;
        run_cycle(3'b111, 1'b0, 1'b0);
        n_cmp++;
        if (rdy_log[0] !== 3'b010 || we_log[1] !== 1'b0 || rdy_log[1] !== 3'b100) begin
            n_bad++;
            $display("FAIL x0: rdy0=%b we1=%b rdy1=%b want 010/0/100",
                     rdy_log[0], we_log[1], rdy_log[1]);
        end
        #1;
        n_cmp++;
        if (x0_cnt_o !== 8'd1 || wr_cnt_o !== 16'd0) begin
            n_bad++;
            $display("FAIL x0_counts: x0=%0d wr=%0d want 1/0", x0_cnt_o, wr_cnt_o);
        end
    endtask

    task automatic test_x0_saturate();
        do_reset();
        a[0] = 5'd0;
        for (int c = 0; c < 260; c++) run_cycle(3'b001, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (x0_cnt_o !== 8'd255 || wr_cnt_o !== 16'd0) begin
            n_bad++;
            $display("FAIL x0_saturate: x0=%0d wr=%0d want 255/0", x0_cnt_o, wr_cnt_o);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        clear_logs();
        a[0] = 5'd7;
        d[0] = 32'hBEEF;
        a[1] = 5'd8;
        a[2] = 5'd9;
        run_cycle(3'b001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) run_cycle(3'b110, 1'b1, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (we_log[c] !== 1'b0 || rdy_log[c] !== 3'b000) begin
                n_bad++;
                $display("FAIL freeze[%0d]: we=%b rdy=%b want 0/000", c, we_log[c], rdy_log[c]);
            end
        end
        n_cmp++;
        if (we_log[4] !== 1'b1 || commit_log.size() != 1 || commit_log[0] !== 5'd7) begin
            n_bad++;
            $display("FAIL freeze_release: we4=%b commits=%0d want 1 commit of 7",
                     we_log[4], commit_log.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        a[0] = 5'd9;
        d[0] = 32'h9999;
        run_cycle(3'b001, 1'b0, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b1);
        a[0] = 5'd1;
        a[1] = 5'd2;
        a[2] = 5'd3;
        run_cycle(3'b111, 1'b0, 1'b0);
        n_cmp++;
        if (we_log[1] !== 1'b0 || commit_log.size() != 0 || rdy_log[2] !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_mid: we=%b commits=%0d rdy_after=%b want 0/0/001",
                     we_log[1], commit_log.size(), rdy_log[2]);
        end
        n_cmp++;
        if (wr_cnt_o !== 16'd0 || x0_cnt_o !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_counts: wr=%0d x0=%0d want 0/0", wr_cnt_o, x0_cnt_o);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        clear_logs();
        a[0] = 5'd3;
        d[0] = 32'h3333;
        a[2] = 5'd4;
        d[2] = 32'h4444;
        run_cycle(3'b101, 1'b0, 1'b0);
        run_cycle(3'b100, 1'b0, 1'b0);
        run_cycle(3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (rdy_log[0] !== 3'b001 || rdy_log[1] !== 3'b100) begin
            n_bad++;
            $display("FAIL stall_grant: rdy=%b,%b want 001,100", rdy_log[0], rdy_log[1]);
        end
        n_cmp++;
        if (commit_log.size() != 2 || commit_log[0] !== 5'd3 || commit_log[1] !== 5'd4) begin
            n_bad++;
            $display("FAIL stall_order: got %0d commits want 3 then 4", commit_log.size());
        end
    endtask

    task automatic test_random();
        logic [2:0] v;
        logic       frz;
        logic       r;
        v = 3'b000;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i]) begin
                    v[i] = ($urandom_range(0, 99) < 60);
                    a[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d[i] = $urandom;
                end
            end
            frz = ($urandom_range(0, 99) < 20);
            r   = ($urandom_range(0, 99) < 2);
            run_cycle(v, frz, r);
            v = v & ~rdy_log[rdy_log.size()-1];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        m_ptr       = 0;
        m_wr        = 0;
        m_x0        = 0;
        rst         = 1'b1;
        freeze_i    = 1'b0;
        req_valid_i = 3'b000;
        req_addr_i  = '0;
        req_data_i  = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = 5'd0;
            d[i] = 32'd0;
        end
        test_reset();
        test_single();
        test_fairness();
        test_x0();
        test_x0_saturate();
        test_freeze();
        test_reset_mid();
        test_stall_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Round-robin arbiter that shares the register file's single write port among several writeback requesters: ALU writeback, load unit, and the switch-driven debug writer. Each requester uses a valid/ready handshake. The winner's address and data are captured into a one-entry output stage, which drives the register file write port one cycle later. A freeze input stalls all writes, and writes to register 0 are absorbed without touching the register file.

## Interface
- NREQ, 3, number of requesters; index 0 = ALU, 1 = load unit, 2 = debug writer
- AW, 5, register address width
- DW, 32, data width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- freeze_i  input  1  write freeze (debug hold); blocks acceptance and writes
- req_valid_i  input  NREQ  per-requester write request
- req_ready_o  output  NREQ  per-requester accept, one-hot or zero
- req_addr_i  input  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
- req_data_i  input  NREQ*DW  packed data, requester i at bits [i*DW +: DW]
- rf_we_o  output  1  register file write enable
- rf_wa_o  output  AW  register file write address
- rf_wd_o  output  DW  register file write data
- grant_o  output  NREQ  one-hot requester whose write is in the output stage (zero when stage empty)
- wr_cnt_o  output  16  committed register file writes, wraps at 2^16
- x0_cnt_o  output  8  absorbed x0 writes, saturates at 255

## Operation
- Handshake: a transfer occurs on requester i when req_valid_i[i] && req_ready_o[i] at a rising edge. Addr and data must be held stable while valid is high and ready is low.
- Acceptance: when freeze_i=0, exactly one valid requester gets ready, chosen by the round-robin pointer. Scan order starts at ptr and proceeds ptr, ptr+1, … mod NREQ; the first valid requester wins.
- When freeze_i=1 or rst=1: req_ready_o=0.
- Pointer: after a transfer from requester i, ptr <= (i+1) mod NREQ. With no transfer, ptr holds. Reset ptr=0.
- Output stage: a register holding pend, addr, data, and grant. A transfer with addr≠0 loads it and sets pend. A transfer with addr=0 does not set pend and increments x0_cnt_o.
- Write: rf_we_o = pend && !freeze_i. When rf_we_o=1 at an edge, pend clears unless a new transfer reloads it the same cycle, and wr_cnt_o increments.
- Freeze mid-operation: a pending write is held with addr, data, and grant stable. It is issued in the first unfrozen cycle, and no new transfer happens until that cycle.
- Simultaneous events: a drain and a new accept in the same cycle is legal, and the new entry replaces the drained one. Back-to-back writes to the same address commit in acceptance order.
- Reset: pend=0, ptr=0, output registers 0, counters 0. Reset in the middle of a pending write discards that write.

## Timing
- req_ready_o is combinational from req_valid_i, ptr, freeze_i, and rst. It must not depend on the rf_* outputs.
- Latency: handshake in cycle N leads to rf_we_o=1 in cycle N+1 when unfrozen.
- Throughput: one write per cycle when unfrozen, sustained under continuous requests.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ cycles.
- Reset values: rf_we_o=0, rf_wa_o=0, rf_wd_o=0, grant_o=0, req_ready_o=0, wr_cnt_o=0, x0_cnt_o=0.
- rf_wa_o, rf_wd_o, and grant_o are registered. rf_we_o is the registered pend gated by freeze_i.

## Structure
- Shared package rf_arb_pkg:
  - AW and DW defaults
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_DBG=2
  - NREQ default
- Sub-module rr_pick: combinational round-robin selector with inputs valid vector, ptr, and enable, and outputs a one-hot grant and the winner index.
- Pointer, output stage, and counters live in rf_wr_arbiter.

## Test plan
- Single request: req_valid_i=3'b001, addr=5, data=0x1234 in cycle 0. Required: ready[0]=1 in cycle 0; rf_we_o=1, rf_wa_o=5, rf_wd_o=0x1234, grant_o=001 in cycle 1; wr_cnt_o=1 after.
- Fairness: all three valid for 6 cycles from reset. Required grant order 0,1,2,0,1,2; rf_we_o high for 6 consecutive cycles starting at cycle 1.
- x0 write: requester 1 writes addr=0, data=0xFFFF. Required: ready[1]=1; rf_we_o stays 0; x0_cnt_o=1; wr_cnt_o unchanged; ptr advances to 2.
- Freeze: accept addr=7 in cycle 0, freeze_i=1 in cycles 1–3. Required: rf_we_o=0 and all ready=0 in cycles 1–3, rf_wa_o=7 held; rf_we_o=1 in cycle 4.
- Reset mid-operation: accept addr=9, then assert rst the next cycle. Required: rf_we_o=0 and no write of 9; counters 0; after reset, requester 0 has priority over 1 and 2.
- Stall hold: requesters 0 and 2 valid; requester 2 loses and holds addr and data. Required: requester 2 accepted the following cycle, writes commit in order 0 then 2.
